irrigation_zone_ctrl: RTL and testbench
=======================================

Name: irrigation_zone_ctrl

Overview:
- Parametrised successor to the single-zone sprinkler/drip irrigation controller.
- Manages ZONES irrigation zones sharing one water tank:
  - internal saturating tank-level model with fill valve and refill hysteresis
  - round-robin zone arbitration, per-zone sprinkler (asp) or drip (got) mode
  - per-zone conflict error flags
  - post-fertigation flush (clean) cycle
- Sits between the request inputs and the LED-matrix/status display.
- Advances on the divided-clock enable tick.

Parameters:
- ZONES, 4, number of irrigation zones (2..8)
- LEVEL_W, 3, tank level width in bits
- LOW_LEVEL, 2, level strictly below which a refill is forced
- FULL_LEVEL, 7, refill target; must be ≤ 2^LEVEL_W-1 and > LOW_LEVEL
- CLEAN_TICKS, 3, length of flush cycle in ticks (≥1)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  one-cycle enable from clock divisor
- req_asp  in  ZONES  sprinkler request per zone
- req_got  in  ZONES  drip request per zone
- fert_req  in  1  fertiliser injection request
- level  out  LEVEL_W  modelled tank level
- fill_valve  out  1  tank inlet valve (VE)
- zone_open  out  ZONES  one-hot open zone valve, 0 when none
- zone_mode  out  1  1 = sprinkler, 0 = drip; valid while zone_open≠0
- clean_active  out  1  flush cycle in progress
- err_flags  out  ZONES  sticky per-zone conflict flags
- state  out  3  FSM state code for display

Behaviour:
Reset and enable:
- reset=0 at a clock edge forces, regardless of tick: level=0, fill_valve=0, zone_open=0, zone_mode=0, clean_active=0, err_flags=0, state=IDLE, rr pointer=0, fert_pending=0, clean counter=0.
- With reset=1, registers update only on edges where tick=1; tick=0 holds everything.

Zone requests:
- Valid request for zone i: req_asp[i] XOR req_got[i].
- req_asp[i]&req_got[i] sets err_flags[i]. The flag is sticky until reset. The zone is ineligible while both are high.

FSM (state codes IDLE=0, FILL=1, IRRIGATE=2, CLEAN=3):
- IDLE:
  - level<LOW_LEVEL → FILL.
  - else fert_pending → CLEAN (zone_open = last granted zone).
  - else any valid request → IRRIGATE: grant the first valid zone at or after the rr pointer (wrapping), latch zone_mode=req_asp[g], set rr pointer=(g+1) mod ZONES.
  - else stay.
- FILL:
  - fill_valve=1; level+=1 per tick, saturating at FULL_LEVEL.
  - When the incremented level equals FULL_LEVEL → IDLE, fill_valve=0 on the same edge.
  - Requests are ignored during FILL.
- IRRIGATE:
  - Per tick, level decreases by 2 (sprinkler) or 1 (drip), floored at 0.
  - fert_req=1 on a tick in drip mode sets fert_pending; it is ignored in sprinkler mode.
  - Exit priority, evaluated on the post-decrement level:
    1. level<LOW_LEVEL → FILL, zone_open=0.
    2. granted zone request no longer valid → IDLE, zone_open=0.
    3. else stay.
- CLEAN:
  - clean_active=1; zone_open = last granted zone, zone_mode=0.
  - level-=1 per tick, floored at 0.
  - After CLEAN_TICKS ticks → IDLE with fert_pending=0 and clean_active=0.
  - If level<LOW_LEVEL after any decrement → FILL, with fert_pending retained and the clean counter restarted on the next entry.
- At most one zone is open at any time. fill_valve and zone_open≠0 are never asserted together.
- Outputs are registered: changes appear the cycle after the qualifying tick edge.

Decomposition:
- Package irrigation_pkg:
  - state enum and codes IDLE/FILL/IRRIGATE/CLEAN
  - MODE_ASP=1, MODE_GOT=0
  - drain rates ASP_DRAIN=2, GOT_DRAIN=1
- Sub-module rr_arbiter: inputs valid vector, pointer, ZONES parameter; outputs grant index and any_valid. Purely combinational.

Test Plan (defaults, tick=1 every cycle):
- Reset then release, no requests → FILL; level 0→7 over 7 ticks with fill_valve=1; then IDLE, fill_valve=0.
- level=7, req_asp=4'b0010 held → zone_open=0010, zone_mode=1; level 5,3,1; then FILL with zone_open=0000 and fill_valve=1.
- level=7, req_got=4'b0101 held → zone 0 granted. Drop req_got[0] after 2 ticks → IDLE, then zone 2 granted next tick. Reassert zone 0 → zone 2 keeps the valve until it drops, then zone 0.
- req_asp[3]=req_got[3]=1 for one tick → err_flags=1000, no grant to zone 3. Flag stays set after inputs clear, until reset=0.
- Drip on zone 1, fert_req pulsed one tick, then request dropped → IDLE, then CLEAN for 3 ticks: clean_active=1, zone_open=0010, level -1 per tick; then IDLE, fert_pending=0.
- Hold tick=0 for 10 cycles mid-IRRIGATE → all outputs frozen. Then assert reset=0 with tick=0 → all outputs take reset values on that edge.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared state codes, mode encodings and drain rates for the multi-zone
// irrigation controller.
package irrigation_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FILL     = 3'd1;
  localparam logic [2:0] IRRIGATE = 3'd2;
  localparam logic [2:0] CLEAN    = 3'd3;

  localparam logic MODE_ASP = 1'b1;
  localparam logic MODE_GOT = 1'b0;

  localparam int ASP_DRAIN = 2;
  localparam int GOT_DRAIN = 1;

  // Subtraction that stops at zero instead of wrapping.
  function automatic int floor_sub(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid zone at or after the pointer,
// wrapping around the zone count.
module rr_arbiter
  import irrigation_pkg::*;
#(
  parameter  int ZONES = 4,
  localparam int IDX_W = $clog2(ZONES)
) (
  input  logic [ZONES-1:0] valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant_o     = '0;
    any_valid_o = 1'b0;
    idx         = '0;
    // Walk from farthest to nearest so the nearest valid zone wins last.
    for (int k = ZONES - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr_i) + k) % ZONES);
      if (valid_i[idx]) begin
        grant_o     = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irrigation_zone_ctrl.sv
// Multi-zone irrigation controller: tank-level model with refill hysteresis,
// round-robin zone grants, conflict flags and a post-fertigation flush cycle.
module irrigation_zone_ctrl
  import irrigation_pkg::*;
#(
  parameter int ZONES       = 4,
  parameter int LEVEL_W     = 3,
  parameter int LOW_LEVEL   = 2,
  parameter int FULL_LEVEL  = 7,
  parameter int CLEAN_TICKS = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic [ZONES-1:0]   req_asp,
  input  logic [ZONES-1:0]   req_got,
  input  logic               fert_req,
  output logic [LEVEL_W-1:0] level,
  output logic               fill_valve,
  output logic [ZONES-1:0]   zone_open,
  output logic               zone_mode,
  output logic               clean_active,
  output logic [ZONES-1:0]   err_flags,
  output logic [2:0]         state
);

  localparam int IDX_W = $clog2(ZONES);
  localparam int CNT_W = $clog2(CLEAN_TICKS + 1);
  localparam logic [LEVEL_W-1:0] LOW_L  = LEVEL_W'(LOW_LEVEL);
  localparam logic [LEVEL_W-1:0] FULL_L = LEVEL_W'(FULL_LEVEL);
  localparam logic [ZONES-1:0]   ONE_Z  = ZONES'(1);

  logic [2:0]         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               fill_q, fill_d;
  logic [ZONES-1:0]   zone_q, zone_d;
  logic               mode_q, mode_d;
  logic               clean_q, clean_d;
  logic [ZONES-1:0]   err_q, err_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               fert_q, fert_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ZONES-1:0]   valid;
  logic [IDX_W-1:0]   grant;
  logic               any_valid;
  logic [LEVEL_W-1:0] irr_level, clean_level, fill_level;

  assign valid = req_asp ^ req_got;

  rr_arbiter #(.ZONES(ZONES)) u_arb (
    .valid_i     (valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .any_valid_o (any_valid)
  );

  assign irr_level   = (mode_q == MODE_ASP) ? LEVEL_W'(floor_sub(int'(level_q), ASP_DRAIN))
                                            : LEVEL_W'(floor_sub(int'(level_q), GOT_DRAIN));
  assign clean_level = LEVEL_W'(floor_sub(int'(level_q), 1));
  assign fill_level  = (level_q >= FULL_L) ? FULL_L : level_q + 1'b1;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fill_d  = fill_q;
    zone_d  = zone_q;
    mode_d  = mode_q;
    clean_d = clean_q;
    err_d   = err_q | (req_asp & req_got);
    ptr_d   = ptr_q;
    last_d  = last_q;
    fert_d  = fert_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (level_q < LOW_L) begin
          state_d = FILL;
          fill_d  = 1'b1;
        end else if (fert_q) begin
          state_d = CLEAN;
          zone_d  = ONE_Z << last_q;
          mode_d  = MODE_GOT;
          clean_d = 1'b1;
          cnt_d   = '0;
        end else if (any_valid) begin
          state_d = IRRIGATE;
          zone_d  = ONE_Z << grant;
          mode_d  = req_asp[grant];
          last_d  = grant;
          ptr_d   = (int'(grant) == ZONES - 1) ? '0 : grant + 1'b1;
        end
      end

      FILL: begin
        level_d = fill_level;
        if (fill_level == FULL_L) begin
          state_d = IDLE;
          fill_d  = 1'b0;
        end
      end

      IRRIGATE: begin
        level_d = irr_level;
        if (fert_req && mode_q == MODE_GOT) fert_d = 1'b1;
        if (irr_level < LOW_L) begin
          state_d = FILL;
          zone_d  = '0;
          fill_d  = 1'b1;
        end else if (!valid[last_q]) begin
          state_d = IDLE;
          zone_d  = '0;
        end
      end

      CLEAN: begin
        level_d = clean_level;
        cnt_d   = cnt_q + 1'b1;
        // A starved tank wins over completion; the pending flush is retried.
        if (clean_level < LOW_L) begin
          state_d = FILL;
          zone_d  = '0;
          clean_d = 1'b0;
          fill_d  = 1'b1;
        end else if (cnt_q == CNT_W'(CLEAN_TICKS - 1)) begin
          state_d = IDLE;
          zone_d  = '0;
          clean_d = 1'b0;
          fert_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next-state value from before the edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
      fill_q  <= 1'b0;
      zone_q  <= '0;
      mode_q  <= 1'b0;
      clean_q <= 1'b0;
      err_q   <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
      fert_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (tick) begin
      state_q <= state_d;
      level_q <= level_d;
      fill_q  <= fill_d;
      zone_q  <= zone_d;
      mode_q  <= mode_d;
      clean_q <= clean_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      fert_q  <= fert_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state        = state_q;
  assign level        = level_q;
  assign fill_valve   = fill_q;
  assign zone_open    = zone_q;
  assign zone_mode    = mode_q;
  assign clean_active = clean_q;
  assign err_flags    = err_q;

endmodule

// File: tb/tb_irrigation_zone_ctrl.sv
// Scenario bench for irrigation_zone_ctrl: each step's expected outputs are
// queued as it is driven and popped for comparison after the tick edge.
module tb_irrigation_zone_ctrl;
  import irrigation_pkg::*;

  logic       clock;
  logic       reset;
  logic       tick;
  logic [3:0] req_asp;
  logic [3:0] req_got;
  logic       fert_req;
  logic [2:0] level;
  logic       fill_valve;
  logic [3:0] zone_open;
  logic       zone_mode;
  logic       clean_active;
  logic [3:0] err_flags;
  logic [2:0] state;

  irrigation_zone_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .req_asp      (req_asp),
    .req_got      (req_got),
    .fert_req     (fert_req),
    .level        (level),
    .fill_valve   (fill_valve),
    .zone_open    (zone_open),
    .zone_mode    (zone_mode),
    .clean_active (clean_active),
    .err_flags    (err_flags),
    .state        (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] lvl;
    logic       fill;
    logic [3:0] zone;
    logic       mode;
    logic       clean;
    logic [3:0] err;
  } snap_t;

  typedef struct packed {
    logic       rst_n;
    logic       tk;
    logic [3:0] asp;
    logic [3:0] got;
    logic       fert;
    snap_t      exp;
  } step_t;

  snap_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic step_t mk(input int rst_n, input int tk, input int asp, input int got,
                               input int fert, input int st, input int lvl, input int fill,
                               input int zone, input int mode, input int clean, input int err);
    step_t s;
    s.rst_n     = 1'(rst_n);
    s.tk        = 1'(tk);
    s.asp       = 4'(asp);
    s.got       = 4'(got);
    s.fert      = 1'(fert);
    s.exp.st    = 3'(st);
    s.exp.lvl   = 3'(lvl);
    s.exp.fill  = 1'(fill);
    s.exp.zone  = 4'(zone);
    s.exp.mode  = 1'(mode);
    s.exp.clean = 1'(clean);
    s.exp.err   = 4'(err);
    return s;
  endfunction

  // zone_mode only carries meaning while a zone valve is open.
  function automatic snap_t observe();
    snap_t o;
    o.st    = state;
    o.lvl   = level;
    o.fill  = fill_valve;
    o.zone  = zone_open;
    o.mode  = (zone_open != 4'b0) ? zone_mode : 1'b0;
    o.clean = clean_active;
    o.err   = err_flags;
    return o;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d lvl=%0d fill=%b zone=%b mode=%b clean=%b err=%b",
                     s.st, s.lvl, s.fill, s.zone, s.mode, s.clean, s.err);
  endfunction

  task automatic apply(input step_t s);
    reset    = s.rst_n;
    tick     = s.tk;
    req_asp  = s.asp;
    req_got  = s.got;
    fert_req = s.fert;
    sb_q.push_back(s.exp);
    @(posedge clock);
    #1;
  endtask

  // Brings the controller to IDLE with a full tank and the pointer at zone 0.
  task automatic reset_and_fill();
    reset = 1'b0; tick = 1'b1; req_asp = '0; req_got = '0; fert_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    snap_t e, o;
    s.push_back(mk(0, 1, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 1, 'b1000, 'b1000, 1,  0, 0, 0, 0, 0, 0, 0));
    s.push_back(mk(0, 0, 'b1111, 0, 1,       0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_fill();
    step_t s[$];
    snap_t e, o;
    s.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    for (int l = 1; l <= 6; l++) s.push_back(mk(1, 1, 0, 0, 0, 1, l, 1, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fill step %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_sprinkler();
    step_t s[$];
    snap_t e, o;
    s.push_back(mk(1, 1, 'b0010, 0, 0, 2, 7, 0, 'b0010, 1, 0, 0));
    s.push_back(mk(1, 1, 'b0010, 0, 0, 2, 5, 0, 'b0010, 1, 0, 0));
    s.push_back(mk(1, 1, 'b0010, 0, 0, 2, 3, 0, 'b0010, 1, 0, 0));
    s.push_back(mk(1, 1, 'b0010, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    for (int l = 2; l <= 6; l++) s.push_back(mk(1, 1, 'b0010, 0, 0, 1, l, 1, 0, 0, 0, 0));
    s.push_back(mk(1, 1, 'b0010, 0, 0, 0, 7, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL sprinkler step %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_round_robin();
    step_t s[$];
    snap_t e, o;
    reset_and_fill();
    s.push_back(mk(1, 1, 0, 'b0101, 0, 2, 7, 0, 'b0001, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0101, 0, 2, 6, 0, 'b0001, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0101, 0, 2, 5, 0, 'b0001, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0100, 0, 0, 4, 0, 0,       0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0100, 0, 2, 4, 0, 'b0100, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0101, 0, 2, 3, 0, 'b0100, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0001, 0, 0, 2, 0, 0,       0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0001, 0, 2, 2, 0, 'b0001, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0001, 0, 1, 1, 1, 0,       0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL round_robin step %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_conflict();
    step_t s[$];
    snap_t e, o;
    reset_and_fill();
    s.push_back(mk(1, 1, 'b1000, 'b1000, 0, 0, 7, 0, 0,       0, 0, 'b1000));
    s.push_back(mk(1, 1, 0, 0, 0,           0, 7, 0, 0,       0, 0, 'b1000));
    s.push_back(mk(1, 1, 0, 'b0100, 0,      2, 7, 0, 'b0100, 0, 0, 'b1000));
    s.push_back(mk(0, 1, 0, 'b0100, 0,      0, 0, 0, 0,       0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL conflict step %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_fert_clean();
    step_t s[$];
    snap_t e, o;
    reset_and_fill();
    s.push_back(mk(1, 1, 0, 'b0010, 0, 2, 7, 0, 'b0010, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 'b0010, 1, 2, 6, 0, 'b0010, 0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0,      0, 5, 0, 0,       0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0,      3, 5, 0, 'b0010, 0, 1, 0));
    s.push_back(mk(1, 1, 0, 0, 0,      3, 4, 0, 'b0010, 0, 1, 0));
    s.push_back(mk(1, 1, 0, 0, 0,      3, 3, 0, 'b0010, 0, 1, 0));
    s.push_back(mk(1, 1, 0, 0, 0,      0, 2, 0, 0,       0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0,      0, 2, 0, 0,       0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fert_clean step %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_fert_sprinkler_ignored();
    step_t s[$];
    snap_t e, o;
    reset_and_fill();
    s.push_back(mk(1, 1, 'b0001, 0, 0, 2, 7, 0, 'b0001, 1, 0, 0));
    s.push_back(mk(1, 1, 'b0001, 0, 1, 2, 5, 0, 'b0001, 1, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0,      0, 3, 0, 0,       0, 0, 0));
    s.push_back(mk(1, 1, 0, 0, 0,      0, 3, 0, 0,       0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fert_sprinkler step %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  task automatic test_tick_hold();
    step_t s[$];
    snap_t e, o;
    reset_and_fill();
    s.push_back(mk(1, 1, 'b0001, 0, 0, 2, 7, 0, 'b0001, 1, 0, 0));
    s.push_back(mk(1, 1, 'b0001, 0, 0, 2, 5, 0, 'b0001, 1, 0, 0));
    for (int k = 0; k < 10; k++)
      s.push_back(mk(1, 0, 'b0100, 'b0100, 1, 2, 5, 0, 'b0001, 1, 0, 0));
    s.push_back(mk(0, 0, 'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      e = sb_q.pop_front();
      o = observe();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL tick_hold step %0d: got %s, expected %s", i, fmt(o), fmt(e));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    tick     = 1'b1;
    req_asp  = '0;
    req_got  = '0;
    fert_req = 1'b0;
    test_reset();
    test_fill();
    test_sprinkler();
    test_round_robin();
    test_conflict();
    test_fert_clean();
    test_fert_sprinkler_ignored();
    test_tick_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
